src_sched: RTL and testbench
============================

Name: src_sched

Overview:
- Sequencing controller between the two 16-bit value producers (Fibonacci, Timer) and the 16-bit consumer path that feeds the display manager.
- Owns the run mode (`modulo`) and the slow-rate selector (`prog`), and generates the slow clock-enable tick from `prog`.
- Grants the tick to exactly one producer and forwards its values through a one-entry valid/ready holding register.
- `prog` and `modulo` are also exported for display.

Parameters:
- BASE_DIV, 1_000_000, clk cycles per tick at prog=0; period = BASE_DIV << prog.
- CNT_W, 32, tick counter width; must hold (BASE_DIV<<7)-1.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, synchronous, active-high
- start_f  in  1  one-cycle pulse: start Fibonacci run
- start_t  in  1  one-cycle pulse: start Timer run
- stop_f_t  in  1  one-cycle pulse: stop current run
- update  in  1  one-cycle pulse: advance prog
- fib_valid  in  1  Fibonacci word available
- fib_data  in  16  Fibonacci word
- fib_en  out  1  Fibonacci step enable (tick-qualified)
- fib_ack  out  1  Fibonacci word accepted this cycle
- tmr_valid  in  1  Timer word available
- tmr_data  in  16  Timer word
- tmr_en  out  1  Timer step enable (tick-qualified)
- tmr_ack  out  1  Timer word accepted this cycle
- out_ready  in  1  consumer accepts out_data
- out_valid  out  1  holding register full
- out_data  out  16  holding register contents
- prog  out  3  current rate selector
- modulo  out  2  current mode: 00 IDLE, 01 FIB, 10 TMR, 11 DRAIN

Behaviour:
- Reset: state=IDLE, prog=0, modulo=00, tick counter=0, holding register empty, out_data=0. All enables and acks are 0. Reset mid-run discards any held word.
- FSM is registered; modulo equals the state encoding.
- IDLE:
  - start_f → FIB.
  - start_t → TMR.
  - Both in the same cycle → FIB (Fibonacci has priority).
  - stop_f_t is ignored.
- FIB / TMR:
  - stop_f_t → DRAIN.
  - start_f / start_t are ignored.
- DRAIN:
  - No enables are issued.
  - → IDLE in the cycle after the holding register is empty; the same cycle if it is already empty.
- update increments prog mod 8 (7 → 0) only in IDLE; it is ignored in other states.
- Tick counter:
  - Held at 0 in IDLE and DRAIN, and cleared whenever prog changes.
  - In FIB/TMR it counts 0 .. (BASE_DIV<<prog)-1 and wraps.
  - tick=1 for one cycle when the counter equals its terminal value.
  - The first tick after entering a run occurs (BASE_DIV<<prog) cycles after the state change.
- Enables: fib_en = tick & (state==FIB); tmr_en = tick & (state==TMR). Both are one-cycle pulses and never high together.
- Accept:
  - Active source only: Fibonacci in FIB, Timer in TMR.
  - ack is combinational: ack = src_valid & (state is FIB/TMR for that source) & (holding empty | (out_valid & out_ready)).
  - On ack, the word is loaded next edge.
  - The inactive source's ack is always 0.
  - No acceptance in DRAIN or IDLE.
- Stop-cycle accept: a word offered in the stop_f_t cycle is still accepted, because acceptance uses the current state. It is then drained.
- Holding register:
  - out_valid=1 while full.
  - Transfer occurs when out_valid & out_ready.
  - Simultaneous transfer and accept keeps it full with the new word, giving full throughput.
  - out_data is stable while out_valid & !out_ready.
  - out_data retains its last value when empty.
- Backpressure: a full register with out_ready=0 gives ack=0. The producer holds valid/data; ticks continue, and the producer is responsible for not overrunning.

Decomposition:
- Shared package holds:
  - Mode encoding constants MODE_IDLE/FIB/TMR/DRAIN, reused by the display manager for digit 6.
  - Width constants DATA_W=16 and PROG_W=3.
- One natural sub-module, `tick_gen`: inputs clk, rst, run, prog; output tick. It contains the counter and the clear-on-prog-change logic.
- FSM, accept logic and holding register stay in `src_sched`.

Test Plan (BASE_DIV=4):
- Reset then idle 50 cycles → modulo=00, prog=0, no fib_en/tmr_en, out_valid=0.
- 3× update in IDLE, then start_f → prog=3, modulo=01; fib_en pulses every 32 cycles, first pulse 32 cycles after the state change; update during FIB leaves prog=3.
- start_f and start_t in the same cycle → modulo=01, tmr_en never asserted; fib_valid=1 with fib_data=16'h0015 and out_ready=1 → fib_ack same cycle, out_data=16'h0015 and out_valid=1 next cycle.
- In TMR, out_ready=0 and tmr_valid=1 with 16'h0002 then 16'h0003 → first word held, tmr_ack=0 for the second; raise out_ready → 0002 consumed and 0003 accepted in the same cycle.
- stop_f_t in the same cycle as tmr_valid (16'h0009) with the register empty → word accepted, modulo=11, no further tmr_en; out_ready=1 → 0009 delivered, then modulo=00.
- rst asserted while in FIB with out_valid=1 → next cycle modulo=00, prog=0, out_valid=0, counter restarts.

Source files
------------

// File: rtl/src_sched_pkg.sv
// Shared definitions for the source scheduler and the display manager.
// Mode encodings double as the FSM state values exported on `modulo`.
package src_sched_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PROG_W = 3;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_FIB   = 2'b01,
        MODE_TMR   = 2'b10,
        MODE_DRAIN = 2'b11
    } mode_e;

    function automatic logic is_run(input mode_e m);
        return (m == MODE_FIB) || (m == MODE_TMR);
    endfunction

endpackage

// File: rtl/src_sched_tick_gen.sv
// Slow clock-enable generator: one-cycle tick every BASE_DIV << prog cycles
// while run is high; the counter is held at zero otherwise.
module tick_gen
    import src_sched_pkg::*;
#(
    parameter int unsigned BASE_DIV = 1_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [PROG_W-1:0] prog,
    output logic              tick
);

    logic [CNT_W-1:0]  r_cnt;
    logic [PROG_W-1:0] r_prog_q;
    logic [CNT_W-1:0]  w_term;
    logic              w_prog_chg;
    logic              w_at_term;

    assign w_term     = (CNT_W'(BASE_DIV) << prog) - CNT_W'(1);
    assign w_prog_chg = (prog != r_prog_q);
    assign w_at_term  = (r_cnt == w_term);
    assign tick       = run & w_at_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_prog_q <= '0;
        end else begin
            r_prog_q <= prog;
            // a rate change restarts the period rather than reusing a stale count
            if (!run || w_prog_chg || w_at_term) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/src_sched.sv
// Run-mode FSM, rate selector and one-entry valid/ready holding register
// arbitrating between the Fibonacci and Timer producers.
module src_sched
    import src_sched_pkg::*;
#(
    parameter int unsigned BASE_DIV = 1_000_000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_f,
    input  logic              start_t,
    input  logic              stop_f_t,
    input  logic              update,
    input  logic              fib_valid,
    input  logic [DATA_W-1:0] fib_data,
    output logic              fib_en,
    output logic              fib_ack,
    input  logic              tmr_valid,
    input  logic [DATA_W-1:0] tmr_data,
    output logic              tmr_en,
    output logic              tmr_ack,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [PROG_W-1:0] prog,
    output logic [1:0]        modulo
);

    mode_e             r_state;
    mode_e             w_state_nxt;
    logic [PROG_W-1:0] r_prog;
    logic              r_hold_valid;
    logic [DATA_W-1:0] r_hold_data;
    logic              w_tick;
    logic              w_run;
    logic              w_room;
    logic              w_xfer;

    assign w_run  = is_run(r_state);
    assign w_xfer = r_hold_valid & out_ready;
    assign w_room = !r_hold_valid | w_xfer;

    tick_gen #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .prog (r_prog),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MODE_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        fib_en      = 1'b0;
        tmr_en      = 1'b0;
        fib_ack     = 1'b0;
        tmr_ack     = 1'b0;
        case (r_state)
            MODE_IDLE: begin
                if (start_f) begin
                    w_state_nxt = MODE_FIB;
                end else if (start_t) begin
                    w_state_nxt = MODE_TMR;
                end
            end
            MODE_FIB: begin
                fib_en  = w_tick;
                fib_ack = fib_valid & w_room;
                if (stop_f_t) begin
                    w_state_nxt = MODE_DRAIN;
                end
            end
            MODE_TMR: begin
                tmr_en  = w_tick;
                tmr_ack = tmr_valid & w_room;
                if (stop_f_t) begin
                    w_state_nxt = MODE_DRAIN;
                end
            end
            MODE_DRAIN: begin
                if (!r_hold_valid) begin
                    w_state_nxt = MODE_IDLE;
                end
            end
            default: w_state_nxt = MODE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prog <= '0;
        end else if (update && (r_state == MODE_IDLE)) begin
            r_prog <= r_prog + PROG_W'(1);
        end
    end

    // an accept in the same cycle as a transfer refills the register directly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (fib_ack) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= fib_data;
        end else if (tmr_ack) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= tmr_data;
        end else if (w_xfer) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign out_valid = r_hold_valid;
    assign out_data  = r_hold_data;
    assign prog      = r_prog;
    assign modulo    = r_state;

endmodule

// File: tb/tb_src_sched.sv
// Directed bench for src_sched with BASE_DIV=4: a vector table for the
// cycle-by-cycle handshake/FSM behaviour plus sequences for tick timing.
module tb_src_sched;

    logic        clk = 1'b0;
    logic        rst, start_f, start_t, stop_f_t, update;
    logic        fib_valid, tmr_valid, out_ready;
    logic [15:0] fib_data, tmr_data;
    logic        fib_en, fib_ack, tmr_en, tmr_ack, out_valid;
    logic [15:0] out_data;
    logic [2:0]  prog;
    logic [1:0]  modulo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    src_sched #(
        .BASE_DIV (4),
        .CNT_W    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_f   (start_f),
        .start_t   (start_t),
        .stop_f_t  (stop_f_t),
        .update    (update),
        .fib_valid (fib_valid),
        .fib_data  (fib_data),
        .fib_en    (fib_en),
        .fib_ack   (fib_ack),
        .tmr_valid (tmr_valid),
        .tmr_data  (tmr_data),
        .tmr_en    (tmr_en),
        .tmr_ack   (tmr_ack),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .prog      (prog),
        .modulo    (modulo)
    );

    typedef struct {
        logic        rst, sf, st, sp, upd, fv;
        logic [15:0] fd;
        logic        tv;
        logic [15:0] td;
        logic        ordy;
        logic        eaf, eat;
        logic [1:0]  em;
        logic [2:0]  ep;
        logic        eov;
        logic [15:0] eod;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, sf, st, sp, upd, fv, input logic [15:0] fd,
        input logic tv, input logic [15:0] td, input logic ordy,
        input logic eaf, eat, input logic [1:0] em, input logic [2:0] ep,
        input logic eov, input logic [15:0] eod);
        vec_t v;
        v.rst = rst; v.sf = sf; v.st = st; v.sp = sp; v.upd = upd;
        v.fv = fv; v.fd = fd; v.tv = tv; v.td = td; v.ordy = ordy;
        v.eaf = eaf; v.eat = eat; v.em = em; v.ep = ep; v.eov = eov; v.eod = eod;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        rst = 1'b0; start_f = 1'b0; start_t = 1'b0; stop_f_t = 1'b0; update = 1'b0;
        fib_valid = 1'b0; fib_data = '0; tmr_valid = 1'b0; tmr_data = '0; out_ready = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        clr_in();
        rst = 1'b1;

        // Reset state, then a long idle stretch
        repeat (3) next_cycle();
        chk("rst modulo", 32'(modulo), 32'd0);
        chk("rst prog", 32'(prog), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk($sformatf("idle fib_en c%0d", k), 32'(fib_en), 32'd0);
            chk($sformatf("idle tmr_en c%0d", k), 32'(tmr_en), 32'd0);
        end
        next_cycle();
        chk("idle modulo", 32'(modulo), 32'd0);
        chk("idle prog", 32'(prog), 32'd0);
        chk("idle out_valid", 32'(out_valid), 32'd0);

        //                rst sf st sp up fv fd        tv td        ordy eaf eat em ep eov eod
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 1, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 16'h0011, 0, 16'h0000, 0,   0, 0, 0, 1, 0, 16'h0000));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 1, 1, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h0015, 0, 16'h0000, 1,   1, 0, 1, 1, 1, 16'h0015));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h00AA, 0,   0, 0, 1, 1, 1, 16'h0015));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0016, 0, 16'h0000, 0,   0, 0, 1, 1, 1, 16'h0015));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0016, 0, 16'h0000, 1,   1, 0, 1, 1, 1, 16'h0016));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1,   0, 0, 1, 1, 0, 16'h0016));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 1, 1, 0, 16'h0016));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 3, 1, 0, 16'h0016));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 1, 0, 16'h0016));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 2, 1, 0, 16'h0016));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0033, 1, 16'h0002, 0,   0, 1, 2, 1, 1, 16'h0002));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0003, 0,   0, 0, 2, 1, 1, 16'h0002));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0003, 1,   0, 1, 2, 1, 1, 16'h0003));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 2, 1, 1, 16'h0003));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 3, 1, 1, 16'h0003));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0044, 0,   0, 0, 3, 1, 1, 16'h0003));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h0044, 1,   0, 0, 3, 1, 0, 16'h0003));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 1, 0, 16'h0003));
        for (int p = 2; p <= 8; p++) begin
            tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 3'(p), 0, 16'h0003));
        end
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 1, 0, 16'h0003));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 1, 1, 0, 16'h0003));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0077, 0, 16'h0000, 0,   1, 0, 1, 1, 1, 16'h0077));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0,   0, 0, 0, 0, 0, 16'h0000));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; start_f = tbl[i].sf; start_t = tbl[i].st;
            stop_f_t = tbl[i].sp; update = tbl[i].upd;
            fib_valid = tbl[i].fv; fib_data = tbl[i].fd;
            tmr_valid = tbl[i].tv; tmr_data = tbl[i].td; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d fib_ack", i), 32'(fib_ack), 32'(tbl[i].eaf));
            chk($sformatf("v%0d tmr_ack", i), 32'(tmr_ack), 32'(tbl[i].eat));
            chk($sformatf("v%0d en_excl", i), 32'(fib_en & tmr_en), 32'd0);
            next_cycle();
            chk($sformatf("v%0d modulo", i), 32'(modulo), 32'(tbl[i].em));
            chk($sformatf("v%0d prog", i), 32'(prog), 32'(tbl[i].ep));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(tbl[i].eod));
        end
        clr_in();

        // prog=3 run: pulses counted from the cycle start_f is presented
        repeat (3) begin
            update = 1'b1;
            next_cycle();
        end
        update = 1'b0;
        chk("prog after 3 updates", 32'(prog), 32'd3);
        start_f = 1'b1;
        next_cycle();
        start_f = 1'b0;
        chk("fib run modulo", 32'(modulo), 32'd1);
        for (int k = 1; k <= 100; k++) begin
            update = (k == 40);
            @(negedge clk);
            chk($sformatf("p3 fib_en c%0d", k), 32'(fib_en), 32'((k % 32) == 0));
            chk($sformatf("p3 tmr_en c%0d", k), 32'(tmr_en), 32'd0);
            next_cycle();
        end
        update = 1'b0;
        chk("prog held in FIB", 32'(prog), 32'd3);

        // Reset mid-run with a held word
        fib_valid = 1'b1; fib_data = 16'h0055; out_ready = 1'b0;
        @(negedge clk);
        chk("pre-rst fib_ack", 32'(fib_ack), 32'd1);
        next_cycle();
        fib_valid = 1'b0;
        chk("pre-rst out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("mid-rst modulo", 32'(modulo), 32'd0);
        chk("mid-rst prog", 32'(prog), 32'd0);
        chk("mid-rst out_valid", 32'(out_valid), 32'd0);
        chk("mid-rst out_data", 32'(out_data), 32'd0);
        start_f = 1'b1;
        next_cycle();
        start_f = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk($sformatf("p0 fib_en c%0d", k), 32'(fib_en), 32'((k % 4) == 0));
            next_cycle();
        end
        stop_f_t = 1'b1;
        next_cycle();
        stop_f_t = 1'b0;
        chk("stop modulo", 32'(modulo), 32'd3);
        @(negedge clk);
        chk("drain fib_en", 32'(fib_en), 32'd0);
        next_cycle();
        chk("drain empty exit", 32'(modulo), 32'd0);

        // Word offered in the stop cycle is accepted and then drained
        start_t = 1'b1;
        next_cycle();
        start_t = 1'b0;
        repeat (2) next_cycle();
        stop_f_t = 1'b1; tmr_valid = 1'b1; tmr_data = 16'h0009; out_ready = 1'b0;
        @(negedge clk);
        chk("stop-cycle tmr_ack", 32'(tmr_ack), 32'd1);
        next_cycle();
        stop_f_t = 1'b0; tmr_data = 16'h000A; out_ready = 1'b1;
        chk("stop-cycle modulo", 32'(modulo), 32'd3);
        chk("stop-cycle out_valid", 32'(out_valid), 32'd1);
        chk("stop-cycle out_data", 32'(out_data), 32'h0009);
        @(negedge clk);
        chk("drain tmr_en", 32'(tmr_en), 32'd0);
        chk("drain tmr_ack", 32'(tmr_ack), 32'd0);
        next_cycle();
        tmr_valid = 1'b0; out_ready = 1'b0;
        chk("drained out_valid", 32'(out_valid), 32'd0);
        chk("drained out_data", 32'(out_data), 32'h0009);
        chk("drained modulo", 32'(modulo), 32'd3);
        w = 0;
        while ((modulo != 2'b00) && (w < 4)) begin
            next_cycle();
            w++;
        end
        chk("drain exit cycles", 32'(w), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
